// File: rtl/pc_sequencer.sv
// Program counter with sequential, jump, branch and call/return (RAS) next-address sources.
// Optional trap/eret support is enabled by defining PC_TRAP_EN.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0]    STEP         = PC_WIDTH'(1),
`ifdef PC_TRAP_EN
    parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR  = PC_WIDTH'(16'h0008),
`endif
    parameter int                     RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_pc,
    input  logic                stall,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                branch_en,
    input  logic [PC_WIDTH-1:0] branch_off,
    input  logic                call_en,
    input  logic                ret_en,
`ifdef PC_TRAP_EN
    input  logic                trap_req,
    input  logic                eret_en,
    output logic [PC_WIDTH-1:0] epc,
`endif
    output logic [PC_WIDTH-1:0] pc_result,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;
    logic [PTR_W-1:0]    top_ptr;
    logic [CNT_W-1:0]    ras_count;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                update;
    logic                do_push;
    logic                do_pop;
`ifdef PC_TRAP_EN
    logic                do_trap;
`endif

    assign update    = reset && en_pc && !stall;
    assign pc_inc    = pc_result + STEP;
    assign top_ptr   = ras_ptr - PTR_W'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

    // ras_ptr always names the next free slot; once full it wraps onto the oldest entry.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        pc_next = pc_result;
`ifdef PC_TRAP_EN
        do_trap = 1'b0;
`endif
        if (update) begin
`ifdef PC_TRAP_EN
            if (trap_req) begin
                do_trap = 1'b1;
                pc_next = TRAP_VECTOR;
            end else if (eret_en) begin
                pc_next = epc;
            end else
`endif
            if (ret_en) begin
                do_pop  = 1'b1;
                pc_next = ras_empty ? pc_inc : ras_mem[top_ptr];
            end else if (call_en) begin
                do_push = 1'b1;
                pc_next = jump_addr;
            end else if (jump_en) begin
                pc_next = jump_addr;
            end else if (branch_en) begin
                pc_next = pc_result + branch_off;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_result <= RESET_VECTOR;
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else begin
            pc_result <= pc_next;
            if (do_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_err <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                if (ras_empty) begin
                    ras_err <= 1'b1;
                end else begin
                    ras_ptr   <= top_ptr;
                    ras_count <= ras_count - CNT_W'(1);
                end
            end
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc <= '0;
        end else if (do_trap) begin
            epc <= pc_result;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters; trap checks when PC_TRAP_EN is defined).
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        en_pc;
    logic        stall;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        branch_en;
    logic [15:0] branch_off;
    logic        call_en;
    logic        ret_en;
    logic [15:0] pc_result;
    logic [15:0] pc_next;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;
`ifdef PC_TRAP_EN
    logic        trap_req;
    logic        eret_en;
    logic [15:0] epc;
`endif

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .en_pc      (en_pc),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .call_en    (call_en),
        .ret_en     (ret_en),
`ifdef PC_TRAP_EN
        .trap_req   (trap_req),
        .eret_en    (eret_en),
        .epc        (epc),
`endif
        .pc_result  (pc_result),
        .pc_next    (pc_next),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_err    (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Set the redirect strobes for the coming edge.
    task automatic applyStimulus(input logic j, input logic b, input logic c, input logic r,
                                 input logic [15:0] addr, input logic [15:0] off);
        jump_en    = j;
        branch_en  = b;
        call_en    = c;
        ret_en     = r;
        jump_addr  = addr;
        branch_off = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        en_pc = 1'b0;
        stall = 1'b0;
`ifdef PC_TRAP_EN
        trap_req = 1'b0;
        eret_en  = 1'b0;
`endif
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        #12;
        checkOutput("rst_pc", pc_result, 16'h0);
        checkOutput("rst_empty", ras_empty, 1);
        checkOutput("rst_full", ras_full, 0);
        checkOutput("rst_err", ras_err, 0);
        checkOutput("rst_next", pc_next, 16'h0);

        @(negedge clk);
        reset = 1'b1;
        en_pc = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("inc", pc_result, i);
        end
        reset = 1'b0;
        #1;
        checkOutput("async_rst", pc_result, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) tick();
        checkOutput("pc5", pc_result, 16'h5);
        stall = 1'b1;
        applyStimulus(1, 0, 0, 0, 16'h0040, 16'h0);
        #1;
        checkOutput("stall_next", pc_next, 16'h5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_hold", pc_result, 16'h5);
        end
        stall = 1'b0;
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("unstall6", pc_result, 16'h6);
        tick();
        checkOutput("unstall7", pc_result, 16'h7);

        en_pc = 1'b0;
        applyStimulus(1, 0, 0, 0, 16'h0040, 16'h0);
        tick();
        checkOutput("en_low_hold", pc_result, 16'h7);
        en_pc = 1'b1;

        applyStimulus(1, 0, 0, 0, 16'hFFFE, 16'h0);
        tick();
        checkOutput("jump", pc_result, 16'hFFFE);
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h0004);
        #1;
        checkOutput("br_next", pc_next, 16'h0002);
        tick();
        checkOutput("br_wrap", pc_result, 16'h0002);
        applyStimulus(0, 1, 0, 0, 16'h0, 16'hFFFE);
        tick();
        checkOutput("br_neg", pc_result, 16'h0000);

        applyStimulus(1, 0, 0, 0, 16'h0010, 16'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 16'h0100, 16'h0);
        tick();
        checkOutput("call1", pc_result, 16'h0100);
        applyStimulus(0, 0, 1, 0, 16'h0200, 16'h0);
        tick();
        checkOutput("call2", pc_result, 16'h0200);
        applyStimulus(0, 0, 0, 1, 16'h0, 16'h0);
        tick();
        checkOutput("ret1", pc_result, 16'h0101);
        tick();
        checkOutput("ret2", pc_result, 16'h0011);
        checkOutput("nest_empty", ras_empty, 1);
        checkOutput("nest_err", ras_err, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 16'h0020 + 16'(i * 16), 16'h0);
            tick();
        end
        checkOutput("ovf_full", ras_full, 1);
        checkOutput("ovf_err", ras_err, 1);
        applyStimulus(0, 0, 0, 1, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("ovf_ret", pc_result, 16'h0051 - 16'(i * 16));
        end
        checkOutput("ovf_empty", ras_empty, 1);
        tick();
        checkOutput("unf_pc", pc_result, 16'h0022);
        checkOutput("unf_empty", ras_empty, 1);
        checkOutput("unf_err", ras_err, 1);

        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        doReset();
        checkOutput("err_clear", ras_err, 0);
        applyStimulus(1, 0, 0, 0, 16'h0070, 16'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 16'h0032, 16'h0);
        tick();
        applyStimulus(0, 0, 1, 0, 16'h0080, 16'h0);
        tick();
        checkOutput("pri_setup", pc_result, 16'h0080);
        applyStimulus(1, 0, 1, 1, 16'h0090, 16'h0);
        tick();
        checkOutput("pri_pc", pc_result, 16'h0033);
        checkOutput("pri_notempty", ras_empty, 0);
        applyStimulus(0, 0, 0, 1, 16'h0, 16'h0);
        tick();
        checkOutput("pri_nopush", pc_result, 16'h0071);
        checkOutput("pri_empty", ras_empty, 1);
        checkOutput("pri_err", ras_err, 0);

`ifdef PC_TRAP_EN
        applyStimulus(0, 0, 1, 0, 16'h00A0, 16'h0);
        tick();
        trap_req = 1'b1;
        applyStimulus(1, 0, 1, 1, 16'h0090, 16'h0);
        tick();
        checkOutput("trap_pc", pc_result, 16'h0008);
        checkOutput("trap_epc", epc, 16'h00A0);
        checkOutput("trap_ras", ras_empty, 0);
        trap_req = 1'b0;
        eret_en  = 1'b1;
        applyStimulus(0, 0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("eret_pc", pc_result, 16'h00A0);
        eret_en = 1'b0;
        applyStimulus(0, 0, 0, 1, 16'h0, 16'h0);
        tick();
        checkOutput("trap_ras_top", pc_result, 16'h0072);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
